dcache_ctrl: RTL and testbench

Direct-mapped, write-through, write-allocate data cache controller for the pipelined 16-bit CPU's MEM stage. It answers EX/MEM-stage loads and stores from an on-chip line array and drives the stall that freezes the pipeline on a miss. It refills 8-word lines from the multi-cycle main memory. Its read data is the MEM stage's load result, which is registered into MEM/WB.

---
 rtl/dcache_ctrl.sv | 158 +++++++++++++++
 tb/tb_dcache_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, write-allocate data cache controller with 8-word line refill.
// Optional hit/miss statistics counters are enabled by defining DCACHE_STATS_EN.
module dcache_ctrl #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rvalid
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 12 - INDEX_BITS;

  typedef enum logic {IDLE, FILL} state_t;

  state_t                  state;
  logic [3:0]              issue_cnt;
  logic [2:0]              beat_cnt;
  logic [11:0]             line_addr;
  logic [LINES-1:0]        valid;
  logic [TAG_W-1:0]        tags [LINES];
  logic [15:0]             data [LINES*8];

  logic [2:0]              word;
  logic [INDEX_BITS-1:0]   index;
  logic [TAG_W-1:0]        tag;
  logic [INDEX_BITS-1:0]   fill_index;
  logic [TAG_W-1:0]        fill_tag;
  logic                    hit;
  logic                    idle;
  logic                    read_hit;
  logic                    write_hit;
  logic                    miss;
  logic                    fill_done;
  logic                    unused_addr_bit;

  assign word       = cpu_addr[3:1];
  assign index      = cpu_addr[3+INDEX_BITS:4];
  assign tag        = cpu_addr[15:4+INDEX_BITS];
  assign fill_index = line_addr[INDEX_BITS-1:0];
  assign fill_tag   = line_addr[11:INDEX_BITS];
  assign unused_addr_bit = cpu_addr[0];

  // A simultaneous read and write request is treated as a write.
  assign hit       = valid[index] && (tags[index] == tag);
  assign idle      = (state == IDLE);
  assign write_hit = idle && cpu_wr && hit;
  assign read_hit  = idle && cpu_rd && !cpu_wr && hit;
  assign miss      = idle && (cpu_rd || cpu_wr) && !hit;
  assign fill_done = (state == FILL) && mem_rvalid && (beat_cnt == 3'd7);

  always_comb begin
    stall     = miss || (state == FILL);
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 16'h0000;
    cpu_rdata = 16'h0000;
    if (write_hit) begin
      mem_req   = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = {cpu_addr[15:1], 1'b0};
      mem_wdata = cpu_wdata;
    end else if ((state == FILL) && !issue_cnt[3]) begin
      mem_req   = 1'b1;
      mem_addr  = {line_addr, issue_cnt[2:0], 1'b0};
    end
    if (read_hit) begin
      cpu_rdata = data[{index, word}];
    end
  end

  // The line is invalidated on entering FILL so an aborted refill never leaves stale data visible.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      issue_cnt <= 4'd0;
      beat_cnt  <= 3'd0;
      line_addr <= 12'h000;
      valid     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss) begin
            line_addr    <= cpu_addr[15:4];
            issue_cnt    <= 4'd0;
            beat_cnt     <= 3'd0;
            valid[index] <= 1'b0;
            state        <= FILL;
          end
        end
        FILL: begin
          if (!issue_cnt[3]) begin
            issue_cnt <= issue_cnt + 4'd1;
          end
          if (mem_rvalid) begin
            beat_cnt <= beat_cnt + 3'd1;
          end
          if (fill_done) begin
            valid[fill_index] <= 1'b1;
            issue_cnt         <= 4'd0;
            beat_cnt          <= 3'd0;
            state             <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (write_hit) begin
        data[{index, word}] <= cpu_wdata;
      end
      if ((state == FILL) && mem_rvalid) begin
        data[{fill_index, beat_cnt}] <= mem_rdata;
      end
      if (fill_done) begin
        tags[fill_index] <= fill_tag;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  // Both counters saturate rather than wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_count  <= 16'h0000;
      miss_count <= 16'h0000;
    end else begin
      if ((read_hit || write_hit) && (hit_count != 16'hFFFF)) begin
        hit_count <= hit_count + 16'd1;
      end
      if (miss && (miss_count != 16'hFFFF)) begin
        miss_count <= miss_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl against a fixed-latency (L=4) memory model
// whose read data is addr ^ 16'hA5A5.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;
`ifdef DCACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  int compared   = 0;
  int mismatched = 0;

  logic [3:0]  pipe_v = 4'b0000;
  logic [15:0] pipe_a [4];
  logic [15:0] issued [$];

  dcache_ctrl #(.INDEX_BITS(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_rd     (cpu_rd),
    .cpu_wr     (cpu_wr),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .stall      (stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  always #5 clk = ~clk;

  // Memory model: a read accepted in cycle c returns in cycle c+4; it ignores the DUT reset.
  always @(posedge clk) begin
    pipe_v    <= {pipe_v[2:0], mem_req && !mem_we};
    pipe_a[0] <= mem_addr;
    pipe_a[1] <= pipe_a[0];
    pipe_a[2] <= pipe_a[1];
    pipe_a[3] <= pipe_a[2];
    if (mem_req && !mem_we) issued.push_back(mem_addr);
  end

  assign mem_rvalid = pipe_v[3];
  assign mem_rdata  = pipe_v[3] ? (pipe_a[3] ^ 16'hA5A5) : 16'h0000;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [15:0] addr, input logic [15:0] wdata);
    cpu_rd    = rd;
    cpu_wr    = wr;
    cpu_addr  = addr;
    cpu_wdata = wdata;
  endtask

  // Starts a request in the next cycle and returns at the negedge of the cycle it completes.
  task automatic doAccess(input logic rd, input logic wr, input logic [15:0] addr,
                          input logic [15:0] wdata, output int stalls);
    stalls = 0;
    @(posedge clk); #1;
    applyStimulus(rd, wr, addr, wdata);
    @(negedge clk);
    while (stall === 1'b1 && stalls < 100) begin
      stalls++;
      @(posedge clk); #1;
      @(negedge clk);
    end
    if (stalls >= 100) checkOutput("stall_timeout", 32'(stalls), 32'd13);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    end
  endtask

  task automatic checkFill(input string tag, input int start, input logic [15:0] base);
    checkOutput({tag, "_count"}, 32'(issued.size() - start), 32'd8);
    for (int k = 0; k < 8; k++) begin
      if (start + k < issued.size())
        checkOutput({tag, "_addr"}, {16'h0, issued[start + k]}, {16'h0, base + 16'(2 * k)});
      else
        checkOutput({tag, "_addr_missing"}, 32'd0, {16'h0, base + 16'(2 * k)});
    end
  endtask

  initial begin
    int stalls;
    int start;

    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_stall", {31'b0, stall}, 32'd0);
    checkOutput("rst_mem_req", {31'b0, mem_req}, 32'd0);
    checkOutput("rst_mem_we", {31'b0, mem_we}, 32'd0);
    checkOutput("rst_mem_addr", {16'h0, mem_addr}, 32'h0);
    checkOutput("rst_mem_wdata", {16'h0, mem_wdata}, 32'h0);
    checkOutput("rst_cpu_rdata", {16'h0, cpu_rdata}, 32'h0);

    // Cold read
    start = issued.size();
    doAccess(1'b1, 1'b0, 16'h0100, 16'h0, stalls);
    checkOutput("cold_stalls", 32'(stalls), 32'd13);
    checkOutput("cold_rdata", {16'h0, cpu_rdata}, 32'hA4A5);
    checkFill("cold_fill", start, 16'h0100);

    // Read hit
    doAccess(1'b1, 1'b0, 16'h010E, 16'h0, stalls);
    checkOutput("hit_stalls", 32'(stalls), 32'd0);
    checkOutput("hit_rdata", {16'h0, cpu_rdata}, 32'hA4AB);
    checkOutput("hit_mem_req", {31'b0, mem_req}, 32'd0);

    // Back-to-back write hits
    doAccess(1'b0, 1'b1, 16'h0104, 16'h1234, stalls);
    checkOutput("wr_stalls", 32'(stalls), 32'd0);
    checkOutput("wr_mem_req", {31'b0, mem_req}, 32'd1);
    checkOutput("wr_mem_we", {31'b0, mem_we}, 32'd1);
    checkOutput("wr_mem_addr", {16'h0, mem_addr}, 32'h0104);
    checkOutput("wr_mem_wdata", {16'h0, mem_wdata}, 32'h1234);
    doAccess(1'b0, 1'b1, 16'h0107, 16'h5555, stalls);
    checkOutput("wr2_stalls", 32'(stalls), 32'd0);
    checkOutput("wr2_mem_addr", {16'h0, mem_addr}, 32'h0106);
    checkOutput("wr2_mem_wdata", {16'h0, mem_wdata}, 32'h5555);
    doAccess(1'b1, 1'b0, 16'h0104, 16'h0, stalls);
    checkOutput("rd_after_wr_stalls", 32'(stalls), 32'd0);
    checkOutput("rd_after_wr", {16'h0, cpu_rdata}, 32'h1234);
    doAccess(1'b1, 1'b0, 16'h0106, 16'h0, stalls);
    checkOutput("rd_after_wr2", {16'h0, cpu_rdata}, 32'h5555);

    // Conflict eviction: 0x0500 shares the index of 0x0100 with a different tag
    start = issued.size();
    doAccess(1'b1, 1'b0, 16'h0500, 16'h0, stalls);
    checkOutput("evict_stalls", 32'(stalls), 32'd13);
    checkOutput("evict_rdata", {16'h0, cpu_rdata}, 32'hA0A5);
    checkFill("evict_fill", start, 16'h0500);
    doAccess(1'b1, 1'b0, 16'h0100, 16'h0, stalls);
    checkOutput("refetch_stalls", 32'(stalls), 32'd13);
    checkOutput("refetch_rdata", {16'h0, cpu_rdata}, 32'hA4A5);
    doAccess(1'b1, 1'b0, 16'h0104, 16'h0, stalls);
    checkOutput("refetch_hit_stalls", 32'(stalls), 32'd0);
    checkOutput("refetch_old_word", {16'h0, cpu_rdata}, 32'hA4A1);

    // Write miss: fill then write-through
    start = issued.size();
    doAccess(1'b0, 1'b1, 16'h2002, 16'hBEEF, stalls);
    checkOutput("wmiss_stalls", 32'(stalls), 32'd13);
    checkOutput("wmiss_mem_req", {31'b0, mem_req}, 32'd1);
    checkOutput("wmiss_mem_we", {31'b0, mem_we}, 32'd1);
    checkOutput("wmiss_mem_addr", {16'h0, mem_addr}, 32'h2002);
    checkOutput("wmiss_mem_wdata", {16'h0, mem_wdata}, 32'hBEEF);
    checkFill("wmiss_fill", start, 16'h2000);
    doAccess(1'b1, 1'b0, 16'h2002, 16'h0, stalls);
    checkOutput("wmiss_rd_stalls", 32'(stalls), 32'd0);
    checkOutput("wmiss_rd", {16'h0, cpu_rdata}, 32'hBEEF);
    doAccess(1'b1, 1'b0, 16'h200C, 16'h0, stalls);
    checkOutput("wmiss_rd_other", {16'h0, cpu_rdata}, 32'h85A9);

    // Reset during the third FILL cycle
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, 16'h3000, 16'h0);
    @(negedge clk);
    checkOutput("abort_miss_stall", {31'b0, stall}, 32'd1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("abort_stall", {31'b0, stall}, 32'd0);
    checkOutput("abort_mem_req", {31'b0, mem_req}, 32'd0);
    idleCycles(8);
    start = issued.size();
    doAccess(1'b1, 1'b0, 16'h3000, 16'h0, stalls);
    checkOutput("abort_reread_stalls", 32'(stalls), 32'd13);
    checkOutput("abort_reread_rdata", {16'h0, cpu_rdata}, 32'h95A5);
    checkFill("abort_fill", start, 16'h3000);

    idleCycles(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
